// File: rtl/fpu_cmp_pkg.sv
// Shared types for the FPU magnitude comparator: compare modes, result flags
// and the per-operand classification produced in the first pipeline stage.
package fpu_cmp_pkg;

    typedef enum logic [1:0] {
        CMP_UNSIGNED = 2'b00,
        CMP_SIGNED   = 2'b01,
        CMP_FLOAT    = 2'b10,
        CMP_RSVD     = 2'b11
    } cmp_mode_t;

    // Result flags; exactly one is set for every valid result.
    typedef struct packed {
        logic lt;
        logic eq;
        logic gt;
        logic unord;
    } cmp_flags_t;

    // Classification of one operand. The fields are only meaningful when the
    // operand is interpreted as a float (sign is also used in signed mode).
    typedef struct packed {
        logic sign;
        logic is_zero;
        logic is_nan;
    } op_class_t;

endpackage

// File: rtl/fpu_cmp_classify.sv
// Combinational classification of one operand: sign bit, zero magnitude
// (either sign) and NaN (exponent all ones with a nonzero mantissa).
module fpu_cmp_classify
    import fpu_cmp_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int EXP_W = 8
) (
    input  logic [WIDTH-1:0] operand,
    output op_class_t        cls
);

    localparam int MANT_W = WIDTH - 1 - EXP_W;

    logic [EXP_W-1:0]  exp_field;
    logic [MANT_W-1:0] mant_field;

    assign exp_field  = operand[WIDTH-2 -: EXP_W];
    assign mant_field = operand[MANT_W-1:0];

    assign cls.sign    = operand[WIDTH-1];
    assign cls.is_zero = ~|operand[WIDTH-2:0];
    assign cls.is_nan  = (&exp_field) & (|mant_field);

endmodule

// File: rtl/fpu_compare.sv
// Two-stage pipelined comparator. S1 captures the operand classes and raw
// unsigned compares together with the mode; S2 resolves them into one-hot
// lt/eq/gt/unord flags and holds the result until the consumer takes it.
module fpu_compare
    import fpu_cmp_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int EXP_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] input1,
    input  logic [WIDTH-1:0] input2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             lt,
    output logic             eq,
    output logic             gt,
    output logic             unord,
    output logic             nan_seen,
    input  logic             nan_clr
);

    logic [WIDTH-1:0] operand [2];
    op_class_t        cls [2];

    assign operand[0] = input1;
    assign operand[1] = input2;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_classify
            fpu_cmp_classify #(
                .WIDTH(WIDTH),
                .EXP_W(EXP_W)
            ) u_classify (
                .operand(operand[gi]),
                .cls    (cls[gi])
            );
        end
    endgenerate

    // Raw compares: full width for integer modes, low WIDTH-1 bits as the
    // float magnitude (exponent and mantissa order like an unsigned number).
    logic lt_u, eq_u, lt_m, eq_m;
    assign lt_u = input1 < input2;
    assign eq_u = input1 == input2;
    assign lt_m = input1[WIDTH-2:0] < input2[WIDTH-2:0];
    assign eq_m = input1[WIDTH-2:0] == input2[WIDTH-2:0];

    logic       s1_valid_reg;
    cmp_mode_t  s1_mode_reg;
    op_class_t  s1_cls_reg [2];
    logic       s1_lt_u_reg, s1_eq_u_reg, s1_lt_m_reg, s1_eq_m_reg;

    logic       out_valid_reg;
    cmp_flags_t flags_reg;
    cmp_flags_t flags_next;
    logic       nan_seen_reg;

    logic s2_load;
    logic s1_adv;

    // S2 loads whenever its slot is empty or being drained; S1 follows.
    assign s2_load  = !out_valid_reg || out_ready;
    assign s1_adv   = !s1_valid_reg || s2_load;
    assign in_ready = s1_adv;

    // S1 valid bit; reset has priority so in_valid is ignored during reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_reg <= 1'b0;
        end else if (s1_adv) begin
            s1_valid_reg <= in_valid;
        end
    end

    // S1 payload: mode travels with its operands so later mode changes never
    // affect pairs already in flight.
    always_ff @(posedge clk) begin
        if (s1_adv && in_valid) begin
            s1_mode_reg   <= cmp_mode_t'(mode);
            s1_cls_reg[0] <= cls[0];
            s1_cls_reg[1] <= cls[1];
            s1_lt_u_reg   <= lt_u;
            s1_eq_u_reg   <= eq_u;
            s1_lt_m_reg   <= lt_m;
            s1_eq_m_reg   <= eq_m;
        end
    end

    // Mode resolve: turn the raw compares and operand classes into flags.
    always_comb begin
        logic gt_u, gt_m, sa, sb;
        flags_next = '0;
        gt_u = !s1_lt_u_reg && !s1_eq_u_reg;
        gt_m = !s1_lt_m_reg && !s1_eq_m_reg;
        sa   = s1_cls_reg[0].sign;
        sb   = s1_cls_reg[1].sign;
        case (s1_mode_reg)
            CMP_SIGNED: begin
                if (sa != sb) begin
                    flags_next.lt = sa;
                    flags_next.gt = sb;
                end else begin
                    flags_next.lt = s1_lt_u_reg;
                    flags_next.eq = s1_eq_u_reg;
                    flags_next.gt = gt_u;
                end
            end
            CMP_FLOAT: begin
                if (s1_cls_reg[0].is_nan || s1_cls_reg[1].is_nan) begin
                    flags_next.unord = 1'b1;
                end else if (s1_cls_reg[0].is_zero && s1_cls_reg[1].is_zero) begin
                    flags_next.eq = 1'b1;
                end else if (sa != sb) begin
                    flags_next.lt = sa;
                    flags_next.gt = sb;
                end else if (!sa) begin
                    flags_next.lt = s1_lt_m_reg;
                    flags_next.eq = s1_eq_m_reg;
                    flags_next.gt = gt_m;
                end else begin
                    // Both negative: larger magnitude is the smaller value.
                    flags_next.lt = gt_m;
                    flags_next.eq = s1_eq_m_reg;
                    flags_next.gt = s1_lt_m_reg;
                end
            end
            default: begin
                flags_next.lt = s1_lt_u_reg;
                flags_next.eq = s1_eq_u_reg;
                flags_next.gt = gt_u;
            end
        endcase
    end

    // S2 output register; flags are held while the consumer stalls.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_reg <= 1'b0;
            flags_reg     <= '0;
        end else if (s2_load) begin
            out_valid_reg <= s1_valid_reg;
            flags_reg     <= s1_valid_reg ? flags_next : '0;
        end
    end

    // Sticky NaN flag; a new NaN result wins over a simultaneous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            nan_seen_reg <= 1'b0;
        end else if (s2_load && s1_valid_reg && flags_next.unord) begin
            nan_seen_reg <= 1'b1;
        end else if (nan_clr) begin
            nan_seen_reg <= 1'b0;
        end
    end

    assign out_valid = out_valid_reg;
    assign lt        = flags_reg.lt;
    assign eq        = flags_reg.eq;
    assign gt        = flags_reg.gt;
    assign unord     = flags_reg.unord;
    assign nan_seen  = nan_seen_reg;

endmodule

// File: tb/tb_fpu_compare.sv
// Testbench for fpu_compare: vector table, hand sequences for latency,
// back-to-back, NaN sticky flag, backpressure and reset, then random traffic
// checked by a scoreboard fed from a value-level reference model.
module tb_fpu_compare;

    localparam int WIDTH = 32;
    localparam int EXP_W = 8;

    localparam logic [3:0] F_LT = 4'b1000;
    localparam logic [3:0] F_EQ = 4'b0100;
    localparam logic [3:0] F_GT = 4'b0010;
    localparam logic [3:0] F_UN = 4'b0001;

    logic             clk = 1'b0;
    logic             reset, in_valid, in_ready, out_valid, out_ready;
    logic             lt, eq, gt, unord, nan_seen, nan_clr;
    logic [1:0]       mode;
    logic [WIDTH-1:0] input1, input2;

    fpu_compare #(.WIDTH(WIDTH), .EXP_W(EXP_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .mode     (mode),
        .input1   (input1),
        .input2   (input2),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .lt       (lt),
        .eq       (eq),
        .gt       (gt),
        .unord    (unord),
        .nan_seen (nan_seen),
        .nan_clr  (nan_clr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0]  f;
        int          id;
        logic [1:0]  m;
        logic [31:0] a;
        logic [31:0] b;
    } sb_t;

    typedef struct {
        logic [1:0]  m;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  f;
    } vec_t;

    sb_t sb_q[$];
    int  next_id = 0;
    int  delivered = 0;
    int  last_out_id = -1;
    bit  last_in_fire = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: floats are mapped to a signed integer value (sign applied to
    // the magnitude), which orders them numerically and makes -0 equal +0.
    function automatic logic [3:0] ref_cmp(input logic [1:0] m, input logic [31:0] a,
                                           input logic [31:0] b);
        longint ka, kb;
        bit nan_a, nan_b;
        if (m == 2'd2) begin
            nan_a = (a[30:23] == 8'hFF) && (a[22:0] != 0);
            nan_b = (b[30:23] == 8'hFF) && (b[22:0] != 0);
            if (nan_a || nan_b) return F_UN;
            ka = longint'(a[30:0]);
            kb = longint'(b[30:0]);
            if (a[31]) ka = -ka;
            if (b[31]) kb = -kb;
        end else if (m == 2'd1) begin
            ka = longint'($signed(a));
            kb = longint'($signed(b));
        end else begin
            ka = longint'(a);
            kb = longint'(b);
        end
        if (ka < kb) return F_LT;
        if (ka == kb) return F_EQ;
        return F_GT;
    endfunction

    // One clock: evaluate handshakes just before the rising edge, update the
    // scoreboard, then return 1 time unit after the edge.
    task automatic tick();
        sb_t e;
        @(negedge clk);
        last_in_fire = 0;
        if (reset) begin
            sb_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_extra: result flags %b with nothing expected",
                             {lt, eq, gt, unord});
                end else begin
                    e = sb_q.pop_front();
                    check($sformatf("sb_flags_id%0d", e.id), 32'({lt, eq, gt, unord}), 32'(e.f));
                    check("sb_onehot", 32'($countones({lt, eq, gt, unord})), 32'd1);
                    last_out_id = e.id;
                    delivered++;
                    $display("OUT id=%0d mode=%0d a=%h b=%h flags(lt,eq,gt,un)=%b expect=%b",
                             e.id, e.m, e.a, e.b, {lt, eq, gt, unord}, e.f);
                end
            end
            if (in_valid && in_ready) begin
                e.f  = ref_cmp(mode, input1, input2);
                e.id = next_id;
                e.m  = mode;
                e.a  = input1;
                e.b  = input2;
                sb_q.push_back(e);
                next_id++;
                last_in_fire = 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] m, input logic [31:0] a, input logic [31:0] b);
        mode   = m;
        input1 = a;
        input2 = b;
    endtask

    function automatic logic [31:0] rand_op();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h8000_0000;
            2: return 32'h7F80_0000;
            3: return 32'hFF80_0000;
            4: return 32'h7FC0_0000 | 32'($urandom_range(0, 255));
            5: return 32'($urandom_range(0, 4));
            default: return $urandom;
        endcase
    endfunction

    vec_t vt[14];
    vec_t bp[4];

    initial begin
        int k, base, first_id, cyc;
        logic [3:0] held;
        logic [31:0] ra;

        reset = 1; in_valid = 0; out_ready = 1; nan_clr = 0;
        drive(2'd0, 32'd0, 32'd0);
        tick();
        tick();
        reset = 0;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_flags", 32'({lt, eq, gt, unord}), 32'd0);
        check("rst_nan_seen", 32'(nan_seen), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Vector table: mode, a, b, expected {lt,eq,gt,unord}
        vt[0]  = '{2'd0, 32'd49,         32'd67,         F_LT};
        vt[1]  = '{2'd1, 32'hFFFF_FFFF,  32'h0000_0001,  F_LT};
        vt[2]  = '{2'd0, 32'hFFFF_FFFF,  32'h0000_0001,  F_GT};
        vt[3]  = '{2'd2, 32'h8000_0000,  32'h0000_0000,  F_EQ};
        vt[4]  = '{2'd2, 32'hC000_0000,  32'hBF80_0000,  F_LT};
        vt[5]  = '{2'd2, 32'h7F80_0000,  32'h7F7F_FFFF,  F_GT};
        vt[6]  = '{2'd3, 32'hFFFF_FFFF,  32'h0000_0001,  F_GT};
        vt[7]  = '{2'd1, 32'h8000_0000,  32'h7FFF_FFFF,  F_LT};
        vt[8]  = '{2'd1, 32'd5,          32'd5,          F_EQ};
        vt[9]  = '{2'd2, 32'h3F80_0000,  32'hBF80_0000,  F_GT};
        vt[10] = '{2'd2, 32'hFF80_0000,  32'h0000_0001,  F_LT};
        vt[11] = '{2'd2, 32'h7F80_0001,  32'h7F80_0001,  F_UN};
        vt[12] = '{2'd0, 32'd0,          32'd0,          F_EQ};
        vt[13] = '{2'd2, 32'h0000_0000,  32'hFF80_0001,  F_UN};

        for (int i = 0; i < 14; i++) begin
            drive(vt[i].m, vt[i].a, vt[i].b);
            in_valid = 1;
            tick();
            check($sformatf("vec%0d_accept", i), 32'(last_in_fire), 32'd1);
            in_valid = 0;
            check($sformatf("vec%0d_lat1", i), 32'(out_valid), 32'd0);
            tick();
            check($sformatf("vec%0d_lat2", i), 32'(out_valid), 32'd1);
            check($sformatf("vec%0d_flags", i), 32'({lt, eq, gt, unord}), 32'(vt[i].f));
            tick();
        end

        // Back-to-back: same pair signed then unsigned, results on consecutive cycles
        drive(2'd1, 32'hFFFF_FFFF, 32'h1);
        in_valid = 1;
        tick();
        drive(2'd0, 32'hFFFF_FFFF, 32'h1);
        tick();
        in_valid = 0;
        check("b2b_first_valid", 32'(out_valid), 32'd1);
        check("b2b_first_flags", 32'({lt, eq, gt, unord}), 32'(F_LT));
        tick();
        check("b2b_second_valid", 32'(out_valid), 32'd1);
        check("b2b_second_flags", 32'({lt, eq, gt, unord}), 32'(F_GT));
        tick();

        // NaN sticky flag: set, set-with-clear, clear
        nan_clr = 1;
        tick();
        nan_clr = 0;
        check("nan_pre_clear", 32'(nan_seen), 32'd0);
        drive(2'd2, 32'h7FC0_0000, 32'h3F80_0000);
        in_valid = 1;
        tick();
        in_valid = 0;
        check("nan_not_yet", 32'(nan_seen), 32'd0);
        tick();
        check("nan_flags", 32'({lt, eq, gt, unord}), 32'(F_UN));
        check("nan_seen_set", 32'(nan_seen), 32'd1);
        tick();
        in_valid = 1;
        tick();
        in_valid = 0;
        nan_clr = 1;
        tick();
        nan_clr = 0;
        check("nan_set_wins", 32'(nan_seen), 32'd1);
        tick();
        nan_clr = 1;
        tick();
        nan_clr = 0;
        check("nan_cleared", 32'(nan_seen), 32'd0);

        // Backpressure: 4 pairs offered against a stalled consumer
        bp[0] = '{2'd0, 32'd1,         32'd2,          F_LT};
        bp[1] = '{2'd0, 32'd5,         32'd5,          F_EQ};
        bp[2] = '{2'd1, 32'd1,         32'hFFFF_FFFF,  F_GT};
        bp[3] = '{2'd2, 32'h7FC0_0000, 32'd0,          F_UN};
        first_id = next_id;
        out_ready = 0;
        k = 0;
        drive(bp[0].m, bp[0].a, bp[0].b);
        in_valid = 1;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (last_in_fire) begin
                k++;
                if (k < 4) drive(bp[k].m, bp[k].a, bp[k].b);
            end
        end
        check("bp_accepted", 32'(k), 32'd2);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        check("bp_out_valid", 32'(out_valid), 32'd1);
        held = {lt, eq, gt, unord};
        tick();
        tick();
        check("bp_flags_stable", 32'({lt, eq, gt, unord}), 32'(held));
        check("bp_held_first", 32'(held), 32'(bp[0].f));
        out_ready = 1;
        base = delivered;
        cyc = 0;
        while ((delivered - base) < 4 && cyc < 40) begin
            tick();
            if (last_in_fire) begin
                k++;
                if (k < 4) drive(bp[k].m, bp[k].a, bp[k].b);
                else in_valid = 0;
            end
            cyc++;
        end
        in_valid = 0;
        check("bp_delivered", 32'(delivered - base), 32'd4);
        check("bp_last_id", 32'(last_out_id), 32'(first_id + 3));

        // Reset mid-stall with two results in flight
        nan_clr = 1;
        tick();
        nan_clr = 0;
        out_ready = 0;
        drive(2'd2, 32'h7FC0_0000, 32'd0);
        in_valid = 1;
        tick();
        drive(2'd0, 32'd3, 32'd3);
        tick();
        check("rs_nan_seen_before", 32'(nan_seen), 32'd1);
        check("rs_stalled", 32'(in_ready), 32'd0);
        drive(2'd0, 32'd9, 32'd8);
        reset = 1;
        tick();
        reset = 0;
        in_valid = 0;
        check("rs_out_valid", 32'(out_valid), 32'd0);
        check("rs_nan_seen", 32'(nan_seen), 32'd0);
        check("rs_in_ready", 32'(in_ready), 32'd1);
        check("rs_flags", 32'({lt, eq, gt, unord}), 32'd0);
        out_ready = 1;
        first_id = next_id;
        drive(2'd0, 32'd10, 32'd20);
        in_valid = 1;
        tick();
        in_valid = 0;
        cyc = 0;
        while (!out_valid && cyc < 10) begin
            tick();
            cyc++;
        end
        check("rs_next_arrives", 32'(out_valid), 32'd1);
        check("rs_next_flags", 32'({lt, eq, gt, unord}), 32'(F_LT));
        tick();
        check("rs_next_id", 32'(last_out_id), 32'(first_id));

        // Random traffic with random backpressure
        for (int c = 0; c < 600; c++) begin
            if (!in_valid || last_in_fire) begin
                in_valid = ($urandom_range(0, 3) != 0);
                ra = rand_op();
                case ($urandom_range(0, 5))
                    0: drive(2'($urandom_range(0, 3)), ra, ra);
                    1: drive(2'($urandom_range(0, 3)), ra, ra ^ 32'h8000_0000);
                    default: drive(2'($urandom_range(0, 3)), ra, rand_op());
                endcase
            end
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        in_valid = 0;
        out_ready = 1;
        cyc = 0;
        while (sb_q.size() > 0 && cyc < 20) begin
            tick();
            cyc++;
        end
        check("drain_empty", 32'(sb_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
